// File: rtl/div_32_seq_pkg.sv
// Shared types and constants for the sequential MIPS DIV/DIVU unit.
package div_pkg;

   localparam int unsigned DIV_W      = 32;
   localparam int unsigned DIV_ITER   = 32;
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_t;

endpackage : div_pkg

// File: rtl/div_32_seq_if.sv
// Request/result bundle between the EX-stage control and the divider.
interface div_32_seq_if #(
   parameter int unsigned WIDTH = 32
);

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic             div_by_zero;

   // Pipeline side: issues operands, observes status and results.
   modport master (
      output start, is_signed, a, b,
      input  busy, done, lo, hi, div_by_zero
   );

   // Divider side.
   modport slave (
      input  start, is_signed, a, b,
      output busy, done, lo, hi, div_by_zero
   );

endinterface : div_32_seq_if

// File: rtl/div_32_seq_sub_33.sv
// Combinational trial subtractor: x - y at full width, split into the low
// bits of the difference and the sign bit of the result.
module sub_33 #(
   parameter int unsigned WIDTH = 33
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-2:0] diff_c,
   output logic             neg_c
);

   logic [WIDTH-1:0] full_c;

   // Single wide subtract; the top bit is the sign of the trial result.
   always_comb begin
      full_c = x - y;
      diff_c = full_c[WIDTH-2:0];
      neg_c  = full_c[WIDTH-1];
   end

endmodule : sub_33

// File: rtl/div_32_seq.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient to lo and remainder to hi, truncating signed semantics.
module div_32_seq
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_W,
   parameter int unsigned ITER  = DIV_ITER   // must equal WIDTH
) (
   input logic          clk,
   input logic          rst,
   div_32_seq_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(ITER);

   state_t           state;
   state_t           next_state;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] mag_b;
   logic             sign_q;
   logic             sign_r;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] hi_q;
   logic             dbz_q;

   logic             b_zero_c;
   logic             last_c;
   logic [WIDTH-1:0] mag_a_c;
   logic [WIDTH-1:0] mag_b_c;
   logic [WIDTH:0]   rem_shift_c;
   logic [WIDTH-1:0] trial_diff_c;
   logic             trial_neg_c;

   logic             do_capture_c;
   logic             do_zero_c;
   logic             do_step_c;
   logic             do_fix_c;
   logic             busy_d_c;
   logic             done_d_c;

   // Operand conditioning and iteration bookkeeping.
   always_comb begin
      b_zero_c    = (bus.b == '0);
      last_c      = (cnt == CNT_W'(ITER - 1));
      mag_a_c     = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      mag_b_c     = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      rem_shift_c = {rem, dvd[WIDTH-1]};
   end

   // Trial subtraction of the divisor magnitude from the shifted remainder.
   sub_33 #(
      .WIDTH (WIDTH + 1)
   ) u_sub (
      .x      (rem_shift_c),
      .y      ({1'b0, mag_b}),
      .diff_c (trial_diff_c),
      .neg_c  (trial_neg_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               next_state = b_zero_c ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_c) begin
               next_state = FIX;
            end
         end
         FIX:     next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath controls and next values of the status outputs.
   always_comb begin
      do_capture_c = 1'b0;
      do_zero_c    = 1'b0;
      do_step_c    = 1'b0;
      do_fix_c     = 1'b0;
      busy_d_c     = 1'b0;
      done_d_c     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               do_capture_c = 1'b1;
               if (b_zero_c) begin
                  do_zero_c = 1'b1;
                  done_d_c  = 1'b1;
               end else begin
                  busy_d_c  = 1'b1;
               end
            end
         end
         RUN: begin
            do_step_c = 1'b1;
            busy_d_c  = 1'b1;
         end
         FIX: begin
            do_fix_c = 1'b1;
            done_d_c = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         dvd    <= '0;
         quot   <= '0;
         rem    <= '0;
         mag_b  <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         lo_q   <= '0;
         hi_q   <= '0;
         dbz_q  <= 1'b0;
      end else begin
         busy_q <= busy_d_c;
         done_q <= done_d_c;

         if (do_capture_c) begin
            sign_q <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sign_r <= bus.is_signed & bus.a[WIDTH-1];
            dvd    <= mag_a_c;
            mag_b  <= mag_b_c;
            rem    <= '0;
            quot   <= '0;
            cnt    <= '0;
            dbz_q  <= b_zero_c;
         end

         // Divide by zero completes straight from the capture cycle.
         if (do_zero_c) begin
            lo_q <= DIV_ZERO_Q;
            hi_q <= bus.a;
         end

         // Restoring step: keep the trial result only when it did not go negative.
         if (do_step_c) begin
            dvd  <= {dvd[WIDTH-2:0], 1'b0};
            rem  <= trial_neg_c ? rem_shift_c[WIDTH-1:0] : trial_diff_c;
            quot <= {quot[WIDTH-2:0], ~trial_neg_c};
            cnt  <= cnt + CNT_W'(1);
         end

         // Sign fix-up: quotient by operand signs, remainder follows the dividend.
         if (do_fix_c) begin
            lo_q <= sign_q ? -quot : quot;
            hi_q <= sign_r ? -rem  : rem;
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.lo          = lo_q;
   assign bus.hi          = hi_q;
   assign bus.div_by_zero = dbz_q;

endmodule : div_32_seq
